// File: rtl/gold_sprite_scheduler.sv
// gold_sprite_scheduler: shares one sprite ROM among nugget slots, picking the lowest-index active slot covering each pixel.
module gold_sprite_scheduler #(
    parameter int N_GOLD   = 10,
    parameter int SPRITE_W = 40,
    parameter int SPRITE_H = 40,
    parameter int ROM_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       curr_x,
    input  logic [9:0]        curr_y,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_idx,
    input  logic [10:0]       cfg_x,
    input  logic [9:0]        cfg_y,
    input  logic              collect_req,
    input  logic [3:0]        collect_idx,
    input  logic              level_restart,
    output logic              collect_ack,
    output logic              collect_was_active,
    output logic              rom_en,
    output logic [10:0]       rom_addr,
    output logic [3:0]        hit_idx,
    output logic              pix_valid,
    output logic [3:0]        pix_idx,
    output logic [N_GOLD-1:0] active_mask,
    output logic [3:0]        remaining,
    output logic              all_collected
);
    localparam logic [3:0] N_IDX = 4'(N_GOLD);
    localparam logic [9:0][10:0] RST_X = {11'd1144, 11'd10, 11'd1144, 11'd262, 11'd766,
                                          11'd640, 11'd1018, 11'd892, 11'd136, 11'd262};
    localparam logic [9:0][9:0] RST_Y = {10'd442, 10'd442, 10'd10, 10'd118, 10'd226,
                                         10'd442, 10'd226, 10'd118, 10'd334, 10'd442};
    logic [10:0] r_x [N_GOLD];
    logic [9:0]  r_y [N_GOLD];
    logic [N_GOLD-1:0] r_active;
    logic [3:0]  r_remaining;
    logic        r_all_collected;
    logic        r_ack;
    logic        r_was_active;
    logic        r_rom_en;
    logic [10:0] r_rom_addr;
    logic [3:0]  r_hit_idx;
    logic [ROM_LAT-1:0]      r_pv;
    logic [ROM_LAT-1:0][3:0] r_pi;
    logic [N_GOLD-1:0] w_hit;
    logic [N_GOLD-1:0] w_mask_nxt;
    logic        w_any;
    logic [3:0]  w_win;
    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic [10:0] w_addr;
    logic        w_collect_ok;
    logic        w_cfg_ok;

    function automatic logic [3:0] popcount(input logic [N_GOLD-1:0] m);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < N_GOLD; i++) c = c + 4'(m[i]);
        return c;
    endfunction

    // Widened compares keep x+W-1 / y+H-1 from wrapping near the field edge.
    for (genvar k = 0; k < N_GOLD; k++) begin : g_hit
        logic [11:0] w_cx, w_xk;
        logic [10:0] w_cy, w_yk;
        assign w_cx = {1'b0, curr_x};
        assign w_xk = {1'b0, r_x[k]};
        assign w_cy = {1'b0, curr_y};
        assign w_yk = {1'b0, r_y[k]};
        assign w_hit[k] = r_active[k] && w_cx >= w_xk && w_cx <= w_xk + 12'(SPRITE_W - 1)
                          && w_cy >= w_yk && w_cy <= w_yk + 11'(SPRITE_H - 1);
    end

    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = N_GOLD - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any = 1'b1;
                w_win = 4'(i);
            end
        end
    end

    assign w_dx   = curr_x - r_x[w_win];
    assign w_dy   = {1'b0, curr_y - r_y[w_win]};
    assign w_addr = w_dx + (w_dy << 5) + (w_dy << 3);

    assign w_collect_ok = collect_req && collect_idx < N_IDX;
    assign w_cfg_ok     = cfg_we && cfg_idx < N_IDX;
    assign w_mask_nxt   = level_restart ? '1
                        : w_collect_ok ? r_active & ~(N_GOLD'(1) << collect_idx)
                        : r_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_GOLD; i++) begin
                r_x[i] <= RST_X[i % 10];
                r_y[i] <= RST_Y[i % 10];
            end
            r_active        <= '1;
            r_remaining     <= 4'(N_GOLD);
            r_all_collected <= 1'b0;
            r_ack           <= 1'b0;
            r_was_active    <= 1'b0;
            r_rom_en        <= 1'b0;
            r_rom_addr      <= '0;
            r_hit_idx       <= '0;
            r_pv            <= '0;
            r_pi            <= '0;
        end else begin
            if (w_cfg_ok) begin
                r_x[cfg_idx] <= cfg_x;
                r_y[cfg_idx] <= cfg_y;
            end
            r_active        <= w_mask_nxt;
            r_remaining     <= popcount(w_mask_nxt);
            r_all_collected <= w_mask_nxt == '0;
            r_ack           <= collect_req;
            r_was_active    <= w_collect_ok ? r_active[collect_idx] : 1'b0;
            r_rom_en        <= w_any;
            r_rom_addr      <= w_any ? w_addr : '0;
            r_hit_idx       <= w_any ? w_win : '0;
            r_pv[0]         <= r_rom_en;
            r_pi[0]         <= r_hit_idx;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pi[i] <= r_pi[i-1];
            end
        end
    end

    assign collect_ack        = r_ack;
    assign collect_was_active = r_was_active;
    assign rom_en             = r_rom_en;
    assign rom_addr           = r_rom_addr;
    assign hit_idx            = r_hit_idx;
    assign pix_valid          = r_pv[ROM_LAT-1];
    assign pix_idx            = r_pi[ROM_LAT-1];
    assign active_mask        = r_active;
    assign remaining          = r_remaining;
    assign all_collected      = r_all_collected;
endmodule

// File: tb/tb_gold_sprite_scheduler.sv
// tb_gold_sprite_scheduler: directed vectors with hand-computed expectations for the nugget scheduler.
module tb_gold_sprite_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] curr_x = '0;
    logic [9:0]  curr_y = '0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_idx = '0;
    logic [10:0] cfg_x = '0;
    logic [9:0]  cfg_y = '0;
    logic        collect_req = 1'b0;
    logic [3:0]  collect_idx = '0;
    logic        level_restart = 1'b0;
    logic        collect_ack, collect_was_active, rom_en, pix_valid, all_collected;
    logic [10:0] rom_addr;
    logic [3:0]  hit_idx, pix_idx, remaining;
    logic [9:0]  active_mask;
    int n_tests = 0;
    int n_fail = 0;

    gold_sprite_scheduler dut (
        .clk(clk), .rst(rst), .curr_x(curr_x), .curr_y(curr_y),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .collect_req(collect_req), .collect_idx(collect_idx), .level_restart(level_restart),
        .collect_ack(collect_ack), .collect_was_active(collect_was_active),
        .rom_en(rom_en), .rom_addr(rom_addr), .hit_idx(hit_idx),
        .pix_valid(pix_valid), .pix_idx(pix_idx), .active_mask(active_mask),
        .remaining(remaining), .all_collected(all_collected)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scan(input int x, input int y);
        curr_x = 11'(x);
        curr_y = 10'(y);
        step();
    endtask

    task automatic collect(input int idx);
        collect_idx = 4'(idx);
        collect_req = 1'b1;
        step();
        collect_req = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        check("rst_mask", active_mask, 10'h3FF);
        check("rst_remaining", remaining, 10);
        check("rst_all", all_collected, 0);
        check("rst_rom_en", rom_en, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_ack", collect_ack, 0);

        scan(262, 442);
        check("tl_en", rom_en, 1);
        check("tl_idx", hit_idx, 0);
        check("tl_addr", rom_addr, 0);
        scan(301, 481);
        check("br_en", rom_en, 1);
        check("br_addr", rom_addr, 1599);
        check("tl_pix_valid", pix_valid, 1);
        check("tl_pix_idx", pix_idx, 0);
        scan(302, 442);
        check("right_edge_en", rom_en, 0);
        check("br_pix_valid", pix_valid, 1);
        scan(261, 442);
        check("left_edge_en", rom_en, 0);
        check("left_edge_addr", rom_addr, 0);
        check("miss_pix_valid", pix_valid, 0);
        scan(1144, 10);
        check("s7_en", rom_en, 1);
        check("s7_idx", hit_idx, 7);
        check("s7_addr", rom_addr, 0);

        curr_x = '0;
        curr_y = '0;
        cfg_we = 1'b1;
        cfg_idx = 4'd3;
        cfg_x = 11'd262;
        cfg_y = 10'd442;
        step();
        cfg_idx = 4'd10;
        cfg_x = 11'd0;
        cfg_y = 10'd0;
        step();
        cfg_we = 1'b0;
        scan(0, 0);
        check("cfg_oob_ignored", rom_en, 0);
        scan(270, 450);
        check("prio_idx", hit_idx, 0);
        check("prio_addr", rom_addr, 328);
        curr_x = '0;
        curr_y = '0;
        collect(0);
        check("c0_ack", collect_ack, 1);
        check("c0_was", collect_was_active, 1);
        check("c0_remaining", remaining, 9);
        scan(270, 450);
        check("s3_idx", hit_idx, 3);
        check("s3_addr", rom_addr, 328);
        check("ack_one_cycle", collect_ack, 0);

        curr_x = '0;
        curr_y = '0;
        level_restart = 1'b1;
        step();
        level_restart = 1'b0;
        check("restart_remaining", remaining, 10);
        collect(5);
        check("c5a_ack", collect_ack, 1);
        check("c5a_was", collect_was_active, 1);
        check("c5a_remaining", remaining, 9);
        collect(5);
        check("c5b_ack", collect_ack, 1);
        check("c5b_was", collect_was_active, 0);
        check("c5b_remaining", remaining, 9);
        check("c5b_mask", active_mask, 10'h3DF);
        scan(766, 226);
        check("s5_gone", rom_en, 0);

        curr_x = '0;
        curr_y = '0;
        for (int k = 0; k < 10; k++) collect(k);
        check("all_remaining", remaining, 0);
        check("all_flag", all_collected, 1);
        check("all_mask", active_mask, 0);
        level_restart = 1'b1;
        collect(2);
        level_restart = 1'b0;
        check("rc_ack", collect_ack, 1);
        check("rc_was", collect_was_active, 0);
        check("rc_mask", active_mask, 10'h3FF);
        check("rc_remaining", remaining, 10);
        check("rc_all", all_collected, 0);

        scan(262, 442);
        curr_x = 11'd263;
        collect(1);
        check("pre_rst_en", rom_en, 1);
        check("pre_rst_pv", pix_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_en", rom_en, 0);
        check("mid_rst_pv", pix_valid, 0);
        check("mid_rst_ack", collect_ack, 0);
        check("mid_rst_mask", active_mask, 10'h3FF);
        check("mid_rst_remaining", remaining, 10);
        scan(1018, 226);
        check("s3_reset_idx", hit_idx, 3);
        check("s3_reset_addr", rom_addr, 0);
        curr_x = '0;
        curr_y = '0;
        collect(12);
        check("oob_ack", collect_ack, 1);
        check("oob_was", collect_was_active, 0);
        check("oob_mask", active_mask, 10'h3FF);
        check("oob_remaining", remaining, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
